seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver_pkg.sv | 33 +++
 rtl/seg_scan_driver_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 113 +++++++++++
 tb/tb_seg_scan_driver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and active-low hex-to-segment decode for the digit scan driver.
package seg_scan_driver_pkg;

    localparam int DIGITS = 4;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Segment pattern is {g,f,e,d,c,b,a}, a lit segment is 0.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational 4-bit code to active-low seven-segment pattern.
module seg_hex_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_decode(code_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with frame-synchronous
// double-buffered updates, per-digit blanking and a dark guard at each slot start.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   digits_in,
    input  logic [DIGITS-1:0]     valid_in,
    input  logic                  load,
    output logic [6:0]            led,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] TC_VAL    = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_VAL = PW'(GUARD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGITS*4-1:0]    disp_q, disp_d, pend_q, pend_d;
    logic [DIGITS-1:0]      val_q, val_d, pval_q, pval_d;
    logic                   pflag_q, pflag_d;
    logic [6:0]             led_q, led_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic                   fd_q, fd_d;

    logic                   tc, boundary;
    logic [3:0]             cur_digit;
    logic [6:0]             cur_seg;

    assign tc        = (presc_q == TC_VAL);
    assign boundary  = tc && (idx_q == LAST_IDX);
    assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .code_i (cur_digit),
        .seg_o  (cur_seg)
    );

    always_comb begin
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = tc ? idx_q + 1'b1 : idx_q;
        disp_d  = disp_q;
        val_d   = val_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        pflag_d = pflag_q;
        fd_d    = boundary;

        // A load landing on the boundary itself bypasses the pending buffer.
        if (boundary) begin
            if (load) begin
                disp_d  = digits_in;
                val_d   = valid_in;
                pflag_d = 1'b0;
            end else if (pflag_q) begin
                disp_d  = pend_q;
                val_d   = pval_q;
                pflag_d = 1'b0;
            end
        end else if (load) begin
            pend_d  = digits_in;
            pval_d  = valid_in;
            pflag_d = 1'b1;
        end

        anode_d = ANODE_OFF;
        led_d   = SEG_BLANK;
        if (presc_q >= GUARD_VAL) begin
            anode_d = ~(DIGITS'(1) << idx_q);
            if (val_q[idx_q]) begin
                led_d = cur_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            val_q   <= '0;
            pend_q  <= '0;
            pval_q  <= '0;
            pflag_q <= 1'b0;
            led_q   <= SEG_BLANK;
            anode_q <= ANODE_OFF;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            val_q   <= val_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            pflag_q <= pflag_d;
            led_q   <= led_d;
            anode_q <= anode_d;
            fd_q    <= fd_d;
        end
    end

    assign led        = led_q;
    assign anode      = anode_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a frame-level reference model.
module tb_seg_scan_driver;

    localparam int RD = 8;
    localparam int GD = 2;
    localparam int FRAME = RD * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  valid_in = '0;
    logic        load = 1'b0;
    logic [6:0]  led;
    logic [3:0]  anode;
    logic        frame_done;

    int n_checks = 0;
    int n_fail = 0;

    // Model: m counts non-reset cycles; position in frame is m % FRAME.
    int          m = 0;
    logic [15:0] md = '0, mp = '0;
    logic [3:0]  mv = '0, mpv = '0;
    bit          mflag = 1'b0;
    logic [11:0] exp_out;

    seg_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .valid_in   (valid_in),
        .load       (load),
        .led        (led),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[c];
    endfunction

    // Drive one cycle, predict {anode, led, frame_done} after the edge, advance the model.
    task automatic step(input bit r, input bit ld, input logic [15:0] din, input logic [3:0] vin);
        int pos, slot, sub;
        logic [3:0] ea;
        logic [6:0] el;
        rst = r; load = ld; digits_in = din; valid_in = vin;
        if (r) begin
            exp_out = {4'b1111, 7'b1111111, 1'b0};
            m = 0; md = '0; mv = '0; mp = '0; mpv = '0; mflag = 1'b0;
        end else begin
            pos = m % FRAME; slot = pos / RD; sub = pos % RD;
            ea = (sub < GD) ? 4'b1111 : ~(4'b0001 << slot);
            el = (sub < GD || !mv[slot]) ? 7'b1111111 : ref_seg(md[slot*4 +: 4]);
            exp_out = {ea, el, (pos == FRAME - 1)};
            if (pos == FRAME - 1) begin
                if (ld) begin md = din; mv = vin; mflag = 1'b0; end
                else if (mflag) begin md = mp; mv = mpv; mflag = 1'b0; end
            end else if (ld) begin
                mp = din; mpv = vin; mflag = 1'b1;
            end
            m++;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic idle_to(input int target_pos, input string name);
        for (int i = 0; i < FRAME && (m % FRAME) != target_pos; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL %s m=%0d got=%h want=%h", name, m, {anode, led, frame_done}, exp_out);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0, 4'h0);
            n_checks++;
            if ({anode, led, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
                n_fail++;
                $display("FAIL reset got=%h want=%h", {anode, led, frame_done}, {4'b1111, 7'b1111111, 1'b0});
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if (led !== 7'b1111111 || {anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL first_frame_blank i=%0d got=%h want=%h", i, {anode, led, frame_done}, exp_out);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        idle_to(10, "pre_load");
        step(0, 1, 16'h1234, 4'hF);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL load_1234 m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
            // Fixed spot check: slot 0 of the frame after the load, past the guard.
            if ((m - 1) % FRAME == 3 && i < FRAME + 8) begin
                n_checks++;
                if ({anode, led} !== {4'b1110, 7'b0011001}) begin
                    n_fail++;
                    $display("FAIL load_slot0 got=%h want=%h", {anode, led}, {4'b1110, 7'b0011001});
                end
            end
        end
    endtask

    task automatic test_guard();
        for (int i = 0; i < 100; i++) begin
            step(0, ($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom));
            n_checks++;
            if ({anode, led, frame_done} !== exp_out || $countones(~anode) > 1) begin
                n_fail++;
                $display("FAIL guard m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
        end
    endtask

    task automatic test_blanking();
        idle_to(5, "pre_blank");
        step(0, 1, 16'h0900, 4'b0100);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL blank m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
            if (i >= FRAME) begin
                n_checks++;
                if (led !== 7'b1111111 && {anode, led} !== {4'b1011, 7'b0010000}) begin
                    n_fail++;
                    $display("FAIL blank_only_slot2 got=%h want=%h", {anode, led}, {4'b1011, 7'b0010000});
                end
            end
        end
    endtask

    task automatic test_overwrite_bypass();
        idle_to(4, "pre_ovw");
        step(0, 1, 16'hAAAA, 4'hF);
        step(0, 1, 16'h5555, 4'hF);
        for (int i = 0; i < FRAME + 4; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL overwrite m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
            if ((m - 1) % RD >= GD && i >= FRAME) begin
                n_checks++;
                if (led !== 7'b0010010) begin
                    n_fail++;
                    $display("FAIL overwrite_5 got=%b want=%b", led, 7'b0010010);
                end
            end
        end
        idle_to(FRAME - 1, "pre_bypass");
        step(0, 1, 16'hFFFF, 4'hF);
        for (int i = 0; i < FRAME; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL bypass m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
            if ((m - 1) % RD >= GD) begin
                n_checks++;
                if (led !== 7'b0001110) begin
                    n_fail++;
                    $display("FAIL bypass_F got=%b want=%b", led, 7'b0001110);
                end
            end
        end
    endtask

    task automatic test_frame_done();
        int pulses = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(0, 0, 16'h0, 4'h0);
            pulses += frame_done;
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL frame_done_seq m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
        end
        n_checks++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL frame_done_count got=%0d want=3", pulses);
        end
        idle_to(2 * RD + 3, "pre_rst");
        step(0, 1, 16'h8888, 4'hF);
        step(1, 0, 16'h0, 4'h0);
        n_checks++;
        if ({anode, led, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            n_fail++;
            $display("FAIL midframe_reset got=%h want=%h", {anode, led, frame_done}, {4'b1111, 7'b1111111, 1'b0});
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(0, 0, 16'h0, 4'h0);
            n_checks++;
            if (led !== 7'b1111111 || {anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL pending_lost m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
                 16'($urandom), 4'($urandom));
            n_checks++;
            if ({anode, led, frame_done} !== exp_out) begin
                n_fail++;
                $display("FAIL random m=%0d got=%h want=%h", m, {anode, led, frame_done}, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_guard();
        test_blanking();
        test_overwrite_bypass();
        test_frame_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
